// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_pkg
//  Purpose  : Shared sample width, grant encodings and scheduler state type
//             for the I2S frame scheduler slice.
//  Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

   localparam int SAMPLE_W = 16;

   // Owner codes double as the one-hot arbiter grant vector
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_S0   = 2'b01;
   localparam logic [1:0] GRANT_S1   = 2'b10;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_EMPTY    = 2'd1,
      ST_FULL     = 2'd2
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_frame_scheduler_if
//  Purpose  : Two stereo sample sources handing pairs to the scheduler with a
//             valid/ready handshake per source.
//  Revision : 1.0 - initial release
// ============================================================================
interface i2s_frame_scheduler_if;
   import i2s_pkg::*;

   logic                       s0_valid;
   logic                       s1_valid;
   logic                       s0_ready;
   logic                       s1_ready;
   logic [SAMPLE_W-1:0]        s0_left;
   logic [SAMPLE_W-1:0]        s0_right;
   logic [SAMPLE_W-1:0]        s1_left;
   logic [SAMPLE_W-1:0]        s1_right;

   // Source side: offers pairs, observes acceptance
   modport master (
      output s0_valid, s1_valid, s0_left, s0_right, s1_left, s1_right,
      input  s0_ready, s1_ready
   );

   // Scheduler side: observes offers, grants acceptance
   modport slave (
      input  s0_valid, s1_valid, s0_left, s0_right, s1_left, s1_right,
      output s0_ready, s1_ready
   );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Two-way combinational arbiter. With both requests active the
//             source not granted last wins; the priority input hands
//             source 0 the grant whenever it requests.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
   input  wire logic [1:0] i_req,   // {source1, source0}
   input  wire logic       i_last,  // 0: source 0 granted last, 1: source 1
   input  wire logic       i_prio,  // fixed priority to source 0
   output      logic [1:0] o_gnt    // one-hot grant
);

   // Pick a winner among the active requests
   always_comb begin
      o_gnt = 2'b00;
      if (i_prio && i_req[0]) begin
         o_gnt = 2'b01;
      end else if (i_req == 2'b11) begin
         o_gnt = i_last ? 2'b01 : 2'b10;
      end else begin
         o_gnt = i_req;
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2s_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_frame_scheduler
//  Purpose  : Accepts stereo pairs from two sources into a one-entry buffer
//             and presents one pair per I2S frame, loaded on the frame tick.
//             Empty frames are flagged as underruns and either muted or
//             repeat the previous pair.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_frame_scheduler
   import i2s_pkg::*;
#(
   parameter int PRIO_MODE     = 0,   // 0: round-robin, 1: source 0 first
   parameter int UNDERRUN_MUTE = 1    // 1: zero on underrun, 0: repeat pair
) (
   input  wire logic                 i_clk,
   input  wire logic                 i_rst_n,
   input  wire logic                 i_enable,
   input  wire logic                 i_frame_tick,
   i2s_frame_scheduler_if.slave      src,
   output      logic [SAMPLE_W-1:0]  o_left,
   output      logic [SAMPLE_W-1:0]  o_right,
   output      logic [1:0]           o_grant,
   output      logic                 o_underrun,
   output      logic [7:0]           o_underrun_cnt
);

   sched_state_t        r_state;
   logic [SAMPLE_W-1:0] r_buf_left;
   logic [SAMPLE_W-1:0] r_buf_right;
   logic [1:0]          r_buf_owner;
   logic                r_last;       // last granted source, 1 = source 1

   logic [1:0]          w_gnt;
   logic                w_active;
   logic                w_open;
   logic                w_xfer;

   rr_arbiter2 u_arb (
      .i_req  ({src.s1_valid, src.s0_valid}),
      .i_last (r_last),
      .i_prio (PRIO_MODE != 0),
      .o_gnt  (w_gnt)
   );

   // A cycle with enable low already behaves as disabled, so no pair is
   // accepted that would be discarded on the next edge anyway.
   assign w_active     = i_enable && (r_state != ST_DISABLED);
   assign w_open       = w_active && (r_state == ST_EMPTY);
   assign w_xfer       = w_open && (w_gnt != GRANT_NONE);
   assign src.s0_ready = w_open && w_gnt[0];
   assign src.s1_ready = w_open && w_gnt[1];

   // Buffer state machine, frame-tick output load and underrun accounting
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_DISABLED;
         r_buf_left     <= '0;
         r_buf_right    <= '0;
         r_buf_owner    <= GRANT_NONE;
         r_last         <= 1'b1;
         o_left         <= '0;
         o_right        <= '0;
         o_grant        <= GRANT_NONE;
         o_underrun     <= 1'b0;
         o_underrun_cnt <= 8'd0;
      end else begin
         o_underrun <= 1'b0;

         if (i_frame_tick) begin
            if (!w_active) begin
               // Disabled frames output silence and are not underruns
               o_left  <= '0;
               o_right <= '0;
               o_grant <= GRANT_NONE;
            end else if (r_state == ST_FULL) begin
               o_left  <= r_buf_left;
               o_right <= r_buf_right;
               o_grant <= r_buf_owner;
            end else begin
               // Empty at the frame start; a same-cycle transfer only
               // fills the buffer for the following frame
               o_underrun <= 1'b1;
               if (o_underrun_cnt != 8'hFF) begin
                  o_underrun_cnt <= o_underrun_cnt + 8'd1;
               end
               if (UNDERRUN_MUTE != 0) begin
                  o_left  <= '0;
                  o_right <= '0;
                  o_grant <= GRANT_NONE;
               end
            end
         end

         if (w_xfer) begin
            r_buf_left  <= w_gnt[1] ? src.s1_left  : src.s0_left;
            r_buf_right <= w_gnt[1] ? src.s1_right : src.s0_right;
            r_buf_owner <= w_gnt;
            r_last      <= w_gnt[1];
         end

         if (!i_enable) begin
            r_state <= ST_DISABLED;
         end else begin
            case (r_state)
               ST_DISABLED: r_state <= ST_EMPTY;
               ST_EMPTY:    if (w_xfer)       r_state <= ST_FULL;
               ST_FULL:     if (i_frame_tick) r_state <= ST_EMPTY;
               default:     r_state <= ST_DISABLED;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_frame_scheduler
//  Purpose  : Scoreboard bench for two scheduler instances (round-robin/mute
//             and fixed-priority/repeat) fed from one shared source stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_frame_scheduler;
   import i2s_pkg::*;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic [1:0]  g;
      logic        u;
      logic [7:0]  c;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b0;
   logic tick  = 1'b0;

   always #5 clk = ~clk;

   i2s_frame_scheduler_if if0 ();
   i2s_frame_scheduler_if if1 ();

   logic [15:0] o_l [2];
   logic [15:0] o_r [2];
   logic [1:0]  o_g [2];
   logic        o_u [2];
   logic [7:0]  o_c [2];

   i2s_frame_scheduler #(.PRIO_MODE(0), .UNDERRUN_MUTE(1)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_frame_tick(tick),
      .src(if0), .o_left(o_l[0]), .o_right(o_r[0]), .o_grant(o_g[0]),
      .o_underrun(o_u[0]), .o_underrun_cnt(o_c[0])
   );

   i2s_frame_scheduler #(.PRIO_MODE(1), .UNDERRUN_MUTE(0)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_frame_tick(tick),
      .src(if1), .o_left(o_l[1]), .o_right(o_r[1]), .o_grant(o_g[1]),
      .o_underrun(o_u[1]), .o_underrun_cnt(o_c[1])
   );

   // ---------------- reference model (per instance) ----------------
   int          pm [2] = '{0, 1};
   int          mu [2] = '{1, 0};
   bit          qv [2];
   logic [15:0] ql [2];
   logic [15:0] qr [2];
   logic [1:0]  qg [2];
   int          last [2];
   logic [15:0] ml [2];
   logic [15:0] mr [2];
   logic [1:0]  mg [2];
   int          mc [2];
   bit          en_prev;

   exp_t q0 [$];
   exp_t q1 [$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic int winner(int prio, int lst, bit a, bit b);
      if (!a && !b)      return -1;
      if (prio != 0 && a) return 0;
      if (a && b)        return (lst == 0) ? 1 : 0;
      return a ? 0 : 1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         qv[d] = 0; ql[d] = 0; qr[d] = 0; qg[d] = 0; last[d] = 1;
         ml[d] = 0; mr[d] = 0; mg[d] = 0; mc[d] = 0;
      end
      en_prev = 0;
      q0.delete();
      q1.delete();
   endtask

   // One clock cycle of stimulus, followed by the model's view of it
   task automatic step(input bit v0, input bit v1,
                       input logic [15:0] l0, input logic [15:0] r0,
                       input logic [15:0] l1, input logic [15:0] r1,
                       input bit tk, input bit e);
      bit         act;
      int         w;
      logic [1:0] er;
      logic [1:0] ar;
      exp_t       ex;
      @(posedge clk);
      #1;
      if0.s0_valid = v0; if0.s1_valid = v1;
      if0.s0_left  = l0; if0.s0_right = r0; if0.s1_left = l1; if0.s1_right = r1;
      if1.s0_valid = v0; if1.s1_valid = v1;
      if1.s0_left  = l0; if1.s0_right = r0; if1.s1_left = l1; if1.s1_right = r1;
      tick = tk;
      en   = e;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         act = e && en_prev;
         w   = (act && !qv[d]) ? winner(pm[d], last[d], v0, v1) : -1;
         er  = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
         ar  = (d == 0) ? {if0.s1_ready, if0.s0_ready} : {if1.s1_ready, if1.s0_ready};
         chk($sformatf("ready%0d", d), {30'd0, ar}, {30'd0, er});
         if (tk) begin
            ex.u = 0;
            if (!act) begin
               ml[d] = 0; mr[d] = 0; mg[d] = 0;
            end else if (qv[d]) begin
               ml[d] = ql[d]; mr[d] = qr[d]; mg[d] = qg[d]; qv[d] = 0;
            end else begin
               ex.u = 1;
               if (mc[d] < 255) mc[d]++;
               if (mu[d] != 0) begin
                  ml[d] = 0; mr[d] = 0; mg[d] = 0;
               end
            end
            ex.l = ml[d]; ex.r = mr[d]; ex.g = mg[d]; ex.c = mc[d][7:0];
            if (d == 0) q0.push_back(ex); else q1.push_back(ex);
         end
         if (!act) qv[d] = 0;
         if (w >= 0) begin
            qv[d]   = 1;
            ql[d]   = (w == 1) ? l1 : l0;
            qr[d]   = (w == 1) ? r1 : r0;
            qg[d]   = er;
            last[d] = w;
         end
      end
      en_prev = e;
   endtask

   task automatic idle(input bit tk, input bit e);
      step(0, 0, 16'd0, 16'd0, 16'd0, 16'd0, tk, e);
   endtask

   task automatic do_reset();
      idle(0, en);
      @(posedge clk);
      #1;
      rst_n = 0;
      tick  = 0;
      en    = 0;
      if0.s0_valid = 0; if0.s1_valid = 0;
      if1.s0_valid = 0; if1.s1_valid = 0;
      #2;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_samples%0d", d), {o_l[d], o_r[d]}, 32'd0);
         chk($sformatf("rst_status%0d", d), {21'd0, o_g[d], o_u[d], o_c[d]}, 32'd0);
      end
      chk("rst_ready", {28'd0, if0.s1_ready, if0.s0_ready, if1.s1_ready, if1.s0_ready}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit          tk;
      exp_t        e;
      logic [15:0] hl [2];
      logic [15:0] hr [2];
      logic [1:0]  hg [2];
      logic [7:0]  hc [2];
      logic        hu;
      for (int d = 0; d < 2; d++) begin
         hl[d] = 0; hr[d] = 0; hg[d] = 0; hc[d] = 0;
      end
      forever begin
         @(posedge clk);
         tk = tick && rst_n;
         @(negedge clk);
         if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
               hl[d] = 0; hr[d] = 0; hg[d] = 0; hc[d] = 0;
            end
         end else begin
            for (int d = 0; d < 2; d++) begin
               hu = 0;
               if (tk) begin
                  if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL scoreboard%0d: output frame with no expected entry at %0t", d, $time);
                  end else begin
                     e = (d == 0) ? q0.pop_front() : q1.pop_front();
                     hl[d] = e.l; hr[d] = e.r; hg[d] = e.g; hc[d] = e.c; hu = e.u;
                  end
               end
               chk($sformatf("samples%0d", d), {o_l[d], o_r[d]}, {hl[d], hr[d]});
               chk($sformatf("status%0d", d), {21'd0, o_g[d], o_u[d], o_c[d]},
                   {21'd0, hg[d], hu, hc[d]});
            end
         end
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   logic [1:0] rr_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      if0.s0_valid = 0; if0.s1_valid = 0;
      if0.s0_left = 0; if0.s0_right = 0; if0.s1_left = 0; if0.s1_right = 0;
      if1.s0_valid = 0; if1.s1_valid = 0;
      if1.s0_left = 0; if1.s0_right = 0; if1.s1_left = 0; if1.s1_right = 0;
      model_reset();
      do_reset();

      // Single source, tick on cycle 10
      for (int c = 1; c <= 12; c++)
         step(1, 0, 16'h1234, 16'hEDCC, 16'd0, 16'd0, c == 10, 1);
      chk("first_pair", {o_l[0], o_r[0]}, 32'h1234EDCC);
      chk("first_grant", {30'd0, o_g[0]}, 32'd1);

      // Both sources always valid: grants must alternate on the RR instance
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 5; k++)
            step(1, 1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1);
         step(1, 1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, 1);
         step(1, 1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1);
         chk($sformatf("rr_grant%0d", t), {30'd0, o_g[0]}, {30'd0, rr_seq[t]});
         chk($sformatf("prio_grant%0d", t), {30'd0, o_g[1]}, 32'd1);
      end

      // Repeat-on-underrun instance holds the last pair
      idle(1, 1);
      step(1, 0, 16'd100, 16'hFF9C, 16'd0, 16'd0, 0, 1);
      idle(0, 1);
      idle(1, 1);
      idle(0, 1);
      idle(0, 1);
      idle(1, 1);
      idle(0, 1);
      chk("hold_pair", {o_l[1], o_r[1]}, {16'd100, 16'hFF9C});
      chk("hold_grant", {30'd0, o_g[1]}, 32'd1);
      chk("mute_pair", {o_l[0], o_r[0], 14'd0, o_g[0]}, 48'd0);

      // Transfer coinciding with a tick in EMPTY
      step(1, 0, 16'h0555, 16'h0AAA, 16'd0, 16'd0, 1, 1);
      idle(0, 1);
      idle(1, 1);
      idle(0, 1);
      chk("late_pair", {o_l[0], o_r[0]}, 32'h05550AAA);
      chk("late_cnt", {24'd0, o_c[0]}, 32'd2);

      // Enable drop while FULL discards the pair
      step(1, 0, 16'h0777, 16'h0888, 16'd0, 16'd0, 0, 1);
      idle(0, 0);
      idle(1, 0);
      idle(0, 0);
      chk("dis_out0", {o_l[0], o_r[0], 14'd0, o_g[0]}, 48'd0);
      chk("dis_out1", {o_l[1], o_r[1], 14'd0, o_g[1]}, 48'd0);
      chk("dis_cnt0", {24'd0, o_c[0]}, mc[0]);

      // 300 empty frames
      idle(0, 1);
      idle(0, 1);
      for (int c = 1; c <= 900; c++)
         idle((c % 3) == 0, 1);
      idle(0, 1);
      chk("sat_cnt0", {24'd0, o_c[0]}, 32'd255);
      chk("sat_cnt1", {24'd0, o_c[1]}, 32'd255);
      chk("sat_mute", {o_l[0], o_r[0]}, 32'd0);

      // Reset in the middle of a frame with a pair on the outputs
      step(1, 1, 16'h4321, 16'h8765, 16'h1111, 16'h2222, 0, 1);
      idle(1, 1);
      idle(0, 1);
      do_reset();

      // Randomised traffic
      for (int c = 0; c < 3000; c++)
         step($urandom_range(0, 1), $urandom_range(0, 1),
              16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 49) != 0);
      idle(0, 1);
      idle(0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2s_frame_scheduler.md
I2S_FRAME_SCHEDULER -- requirements
Module: i2s_frame_scheduler

Interface
REQ-001 Parameter PRIO_MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority to source 0.
REQ-002 Parameter UNDERRUN_MUTE, default 1, underrun frame value: 1 = output zero, 0 = repeat previous pair.
REQ-003 i_clk  in  1  single system clock (12 MHz); all logic on rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_enable  in  1  scheduler enable, level.
REQ-006 i_frame_tick  in  1  one-cycle pulse at the start of each I2S frame (left-slot load point).
REQ-007 s0_valid / s1_valid  in  1 each  source has a stereo pair available.
REQ-008 s0_ready / s1_ready  out  1 each  scheduler accepts the pair this cycle.
REQ-009 s0_left, s0_right, s1_left, s1_right  in  16 each  signed two's-complement samples.
REQ-010 o_left, o_right  out  16 each  registered samples for the I2S transmitter, stable for a whole frame.
REQ-011 o_grant  out  2  owner of current output pair: 00 none, 01 source 0, 10 source 1.
REQ-012 o_underrun  out  1  one-cycle pulse, frame tick with no buffered pair.
REQ-013 o_underrun_cnt  out  8  saturating underrun count.

Function
REQ-014 One-entry buffer (left, right, owner); state machine DISABLED, EMPTY, FULL.
REQ-015 DISABLED: i_enable=0; both ready low; buffer invalid; -> EMPTY when i_enable=1.
REQ-016 EMPTY: exactly one ready high, to the arbitration winner among valid sources; none if neither valid; ready may depend combinationally on valid.
REQ-017 Transfer occurs when sX_valid && sX_ready; buffer captures that pair and owner; -> FULL next cycle.
REQ-018 FULL: both ready low; on i_frame_tick, o_left/o_right <= buffer, o_grant <= owner, -> EMPTY.
REQ-019 Latency: pair accepted in cycle N appears on outputs the cycle after the first i_frame_tick at cycle >= N+1.
REQ-020 Frame tick in EMPTY (including a same-cycle transfer): that frame is an underrun; any same-cycle transfer goes to the buffer only; o_underrun pulses; counter increments, saturating at 255.
REQ-021 Underrun output: UNDERRUN_MUTE=1 -> o_left=o_right=0, o_grant=00; UNDERRUN_MUTE=0 -> pair and o_grant held.
REQ-022 Round-robin: pointer records the last granted source and updates only on transfer; if both valid, the non-last source wins; after reset, source 0 wins.
REQ-023 PRIO_MODE=1: source 0 wins whenever s0_valid=1.
REQ-024 i_enable falling in any state: next cycle DISABLED, buffered pair discarded, outputs held until next frame tick, which then loads zero with o_grant=00 and no underrun count.
REQ-025 Frame tick while DISABLED: no underrun pulse, counter unchanged.
REQ-026 Outputs change only in the cycle after i_frame_tick, except on reset.

Reset
REQ-027 When i_rst_n=0, all state shall clear asynchronously: state DISABLED, buffer invalid, RR pointer -> source 1 (so source 0 wins first), o_left=o_right=0, o_grant=00, o_underrun=0, o_underrun_cnt=0, both ready low.
REQ-028 Reset deassertion is synchronised externally; mid-transfer reset drops the pair without acknowledgement.

Structure
REQ-029 Shared package i2s_pkg holds SAMPLE_W=16, grant encodings (GRANT_NONE/S0/S1), and the state enumeration.
REQ-030 One sub-module, rr_arbiter2: two requests and pointer in, one-hot grant out, combinational, with fixed-priority override input.

Verification
REQ-031 Reset, enable=1, only s0 valid with (0x1234, 0xEDCC), tick at cycle 10 -> outputs 0x1234/0xEDCC, o_grant=01 at cycle 11.
REQ-032 RR, both sources continuously valid, 4 ticks -> o_grant sequence 01, 10, 01, 10; never both ready high.
REQ-033 No valid for 300 ticks, UNDERRUN_MUTE=1 -> 300 o_underrun pulses, outputs 0, o_underrun_cnt=255.
REQ-034 UNDERRUN_MUTE=0, pair (100, -100) loaded, next tick empty -> outputs stay 100/-100, o_grant=01, one underrun pulse.
REQ-035 Transfer in the same cycle as tick while EMPTY -> underrun counted; pair appears after the following tick.
REQ-036 i_enable low while FULL, then tick -> outputs 0, o_grant=00, no underrun; i_rst_n pulse mid-frame -> all outputs 0 immediately.
